vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives DrawX/DrawY, blank, hs and vs to every sprite/background renderer and to the HDMI/VGA output encoder.
- Sits directly upstream of each sprite block: a renderer samples DrawX/DrawY/blank on the same vga_clk and registers RGB one cycle later.
- Optionally provides a free-running frame counter for sprite animation.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock. The block has one clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- blank  out  1  1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = porch/sync
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- frame_start  out  1  one-cycle pulse when the position wraps to (0,0)
- frame_cnt  out  8  frames completed, modulo 256

## Operation
- Totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
  - Elaboration error if either total exceeds 1024.
- Horizontal counter hc increments every cycle and wraps H_TOTAL-1 -> 0.
- Vertical counter vc increments only on an hc wrap and wraps V_TOTAL-1 -> 0 on that same cycle.
- DrawX = hc and DrawY = vc, both driven straight from the registers.
- hs = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
- vs = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
- vs transitions only at hc = 0.
- blank, hs, vs and frame_start are registered decodes of the next counter values. They are therefore aligned with the DrawX/DrawY presented in the same cycle; no extra skew relative to position.
- frame_start = 1 exactly in cycles where (DrawX,DrawY) = (0,0) was reached by wrap from (H_TOTAL-1,V_TOTAL-1).
- frame_cnt increments by 1 on the same edge frame_start rises, and wraps 255 -> 0.

## Timing
- Reset values (asynchronous on reset_n=0): DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, frame_cnt=0.
- blank is forced 0 while reset_n is low.
- First rising edge after reset_n deasserts: DrawX=1, DrawY=0, blank=1, hs=1, vs=1. No frame_start pulse follows reset.
- Line period is 800 cycles; frame period is 420000 cycles.
- frame_start is high for exactly 1 cycle per frame.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). The counters restart from (0,0) with no partial-frame pulse.
- Downstream contract: a renderer registers RGB on the next vga_clk edge. Its pixel is therefore one cycle behind hs/vs. This skew is accepted by the display and is not compensated here.

## Configuration
- VGA_FRAME_CNT_EN defined: the frame_cnt register is instantiated and behaves as in Operation.
- VGA_FRAME_CNT_EN undefined: no counter flops; frame_cnt is tied to 8'h00. frame_start behaves identically in both builds.

## Structure
- Package vga_pkg holds:
  - default timing constants (H_VISIBLE..V_BP);
  - the derived H_TOTAL/V_TOTAL;
  - typedef logic [9:0] coord_t, used for DrawX/DrawY by all renderers.
- No sub-module; both counters and the sync/blank decode live in one module.

## Test plan
- Reset held 10 cycles, then released -> during reset all outputs at reset values; first edge after release gives DrawX=1, blank=1.
- Run one line -> hs=0 for exactly 96 cycles (DrawX 656..751); blank=0 for DrawX 640..799; DrawY increments when DrawX goes 799 -> 0.
- Run one frame -> vs=0 for exactly 1600 cycles (DrawY 490..491, vs edges at DrawX=0); blank=0 for every DrawY>=480; frame_start single pulse after 420000 cycles.
- Run 257 frames with VGA_FRAME_CNT_EN -> frame_cnt reads 1 after the 257th pulse, proving the 255 -> 0 wrap; without the macro frame_cnt stays 0.
- Assert reset_n low at DrawX=300, DrawY=200 -> outputs reset asynchronously the same cycle; after release the sequence restarts from (1,0) with no frame_start.
- Override parameters to H_VISIBLE=8, H_FP=2, H_SYNC=2, H_BP=2, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1 -> line period 14, frame period 98, hs low at DrawX 10..11, vs low at DrawY 5.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster constants and the coordinate type.
// Default timing is 640x480@60 Hz from a 25 MHz pixel clock.
// Every renderer imports coord_t so DrawX/DrawY widths agree across the design.
package vga_pkg;

    // Default 640x480@60 horizontal timing, in pixels.
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    // Default 640x480@60 vertical timing, in lines.
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // Derived totals: 800 pixels per line, 525 lines per frame.
    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Raster coordinate. Ten bits, so neither total may exceed 1024.
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (position, blank, active-low syncs).
// blank/hs/vs/frame_start are registered from the next counter values, so
// they line up with the DrawX/DrawY presented in the same cycle.
// Build option: define VGA_FRAME_CNT_EN to include the 8-bit frame counter;
// without it frame_cnt is tied to zero and no counter flops exist.
// There are no handshakes: every output is valid on every vga_clk cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = V_VISIBLE + V_FP + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    // The counters are COORD_W bits wide; larger rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    coord_t hc;
    coord_t vc;
    coord_t hc_next;
    coord_t vc_next;
    logic   h_wrap;
    logic   frame_wrap;
    logic   blank_next;
    logic   hs_next;
    logic   vs_next;

    // Next raster position and the decodes of that position.
    // Decodes compare in int so a sync end of exactly 1024 cannot alias to 0.
    always_comb begin
        h_wrap     = (hc == H_LAST);
        frame_wrap = h_wrap && (vc == V_LAST);
        hc_next    = h_wrap ? '0 : hc + coord_t'(1);
        vc_next    = vc;
        if (h_wrap) begin
            vc_next = (vc == V_LAST) ? '0 : vc + coord_t'(1);
        end
        blank_next = (int'(hc_next) < H_VISIBLE) && (int'(vc_next) < V_VISIBLE);
        hs_next    = !((int'(hc_next) >= HS_START) && (int'(hc_next) < HS_END));
        // vc_next only moves on an h wrap, so vs can only change at DrawX = 0.
        vs_next    = !((int'(vc_next) >= VS_START) && (int'(vc_next) < VS_END));
    end

    // Position counters plus registered decodes; reset parks at (0,0) blanked.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            blank       <= blank_next;
            hs          <= hs_next;
            vs          <= vs_next;
            // Only a true wrap from the last pixel pulses; leaving reset does not.
            frame_start <= frame_wrap;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

`ifdef VGA_FRAME_CNT_EN
    // Frames completed, counted on the same edge that raises frame_start.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'h00;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'h01;
        end
    end
`else
    assign frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the raster generator.
// dut_d uses the default 800x525 timing (reset and line behaviour);
// dut_s uses a 14x7 raster so whole frames and the frame counter wrap
// fit in a short run. Expected observations are hand-computed and queued
// per instance; a monitor per instance pops and compares at the cycle due.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int EXP_W = 64;  // {cycle[31:0], dx, dy, blank, hs, vs, fs, fc}

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic vga_clk = 1'b0;
    logic rst_d_n = 1'b0;
    logic rst_s_n = 1'b0;

    always #5 vga_clk = ~vga_clk;

    coord_t     dx_d, dy_d, dx_s, dy_s;
    logic       blank_d, hs_d, vs_d, fs_d;
    logic       blank_s, hs_s, vs_s, fs_s;
    logic [7:0] fc_d, fc_s;

    vga_timing_gen dut_d (
        .vga_clk     (vga_clk),
        .reset_n     (rst_d_n),
        .DrawX       (dx_d),
        .DrawY       (dy_d),
        .blank       (blank_d),
        .hs          (hs_d),
        .vs          (vs_d),
        .frame_start (fs_d),
        .frame_cnt   (fc_d)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_s (
        .vga_clk     (vga_clk),
        .reset_n     (rst_s_n),
        .DrawX       (dx_s),
        .DrawY       (dy_s),
        .blank       (blank_s),
        .hs          (hs_s),
        .vs          (vs_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    // Rising edges since reset release (0 while in reset).
    int unsigned cyc_d = 0;
    int unsigned cyc_s = 0;

    always @(posedge vga_clk or negedge rst_d_n) begin
        if (!rst_d_n) cyc_d <= 0;
        else          cyc_d <= cyc_d + 1;
    end

    always @(posedge vga_clk or negedge rst_s_n) begin
        if (!rst_s_n) cyc_s <= 0;
        else          cyc_s <= cyc_s + 1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [EXP_W-1:0] exp_d_q[$];
    logic [EXP_W-1:0] exp_s_q[$];
    logic [EXP_W-1:0] e_d, e_s;

    int   hs_low_d      = 0;
    int   blank_low_d   = 0;
    int   vs_low_s      = 0;
    int   fs_cnt_s      = 0;
    int   vs_edge_bad_s = 0;
    int   blank_bad_s   = 0;
    int   run_s         = 0;
    logic vs_prev_s     = 1'b1;

    function automatic logic [EXP_W-1:0] mk(int unsigned c, int x, int y,
                                            logic b, logic h, logic v, logic f, int fc);
        return {c, 10'(x), 10'(y), b, h, v, f, 8'(fc)};
    endfunction

    function automatic int fcv(int v);
        return FC_ON ? v : 0;
    endfunction

    task automatic compare(string who, int unsigned c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s@%0d: got dx=%0d dy=%0d blank=%0b hs=%0b vs=%0b fs=%0b fc=%0d, want dx=%0d dy=%0d blank=%0b hs=%0b vs=%0b fs=%0b fc=%0d",
                     who, c, act[31:22], act[21:12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[31:22], exp[21:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor for dut_d: pop entries whose cycle has come; tally one full line.
    always @(negedge vga_clk) begin
        while (exp_d_q.size() > 0 && exp_d_q[0][63:32] <= cyc_d) begin
            e_d = exp_d_q.pop_front();
            if (e_d[63:32] < cyc_d) begin
                n_checks++;
                n_fail++;
                $display("FAIL d_stale: entry for cycle %0d seen at cycle %0d", e_d[63:32], cyc_d);
            end else begin
                compare("d_pos", cyc_d, {dx_d, dy_d, blank_d, hs_d, vs_d, fs_d, fc_d}, e_d[31:0]);
            end
        end
        if (rst_d_n && cyc_d >= 800 && cyc_d < 1600) begin
            if (!hs_d)    hs_low_d++;
            if (!blank_d) blank_low_d++;
        end
    end

    // Monitor for dut_s: same popping, plus frame-level tallies.
    always @(negedge vga_clk) begin
        while (exp_s_q.size() > 0 && exp_s_q[0][63:32] <= cyc_s) begin
            e_s = exp_s_q.pop_front();
            if (e_s[63:32] < cyc_s) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_stale: entry for cycle %0d seen at cycle %0d", e_s[63:32], cyc_s);
            end else begin
                compare("s_pos", cyc_s, {dx_s, dy_s, blank_s, hs_s, vs_s, fs_s, fc_s}, e_s[31:0]);
            end
        end
        if (rst_s_n && cyc_s >= 1) begin
            if (run_s == 0 && cyc_s <= 25186 && !vs_s) vs_low_s++;
            if (fs_s) fs_cnt_s++;
            if (vs_s !== vs_prev_s && dx_s != 0) vs_edge_bad_s++;
            if (blank_s && (dx_s >= 8 || dy_s >= 4)) blank_bad_s++;
        end
        vs_prev_s = vs_s;
    end

    // ---------------- driver threads ----------------
    task automatic drive_default();
        //                  cyc    dx   dy  b  hs vs fs fc
        exp_d_q.push_back(mk(0,     0,   0, 0, 1, 1, 0, 0));
        exp_d_q.push_back(mk(1,     1,   0, 1, 1, 1, 0, 0));
        exp_d_q.push_back(mk(639, 639,   0, 1, 1, 1, 0, 0));
        exp_d_q.push_back(mk(640, 640,   0, 0, 1, 1, 0, 0));
        exp_d_q.push_back(mk(655, 655,   0, 0, 1, 1, 0, 0));
        exp_d_q.push_back(mk(656, 656,   0, 0, 0, 1, 0, 0));
        exp_d_q.push_back(mk(751, 751,   0, 0, 0, 1, 0, 0));
        exp_d_q.push_back(mk(752, 752,   0, 0, 1, 1, 0, 0));
        exp_d_q.push_back(mk(799, 799,   0, 0, 1, 1, 0, 0));
        exp_d_q.push_back(mk(800,   0,   1, 1, 1, 1, 0, 0));
        exp_d_q.push_back(mk(1439, 639,  1, 1, 1, 1, 0, 0));
        exp_d_q.push_back(mk(1440, 640,  1, 0, 1, 1, 0, 0));
        exp_d_q.push_back(mk(1600,   0,  2, 1, 1, 1, 0, 0));
        repeat (10) @(negedge vga_clk);
        rst_d_n = 1'b1;
        wait (cyc_d == 1610);
    endtask

    task automatic drive_small();
        //                  cyc     dx dy  b  hs vs fs fc
        exp_s_q.push_back(mk(0,      0, 0, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(1,      1, 0, 1, 1, 1, 0, 0));
        exp_s_q.push_back(mk(7,      7, 0, 1, 1, 1, 0, 0));
        exp_s_q.push_back(mk(8,      8, 0, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(10,    10, 0, 0, 0, 1, 0, 0));
        exp_s_q.push_back(mk(11,    11, 0, 0, 0, 1, 0, 0));
        exp_s_q.push_back(mk(12,    12, 0, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(13,    13, 0, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(14,     0, 1, 1, 1, 1, 0, 0));
        exp_s_q.push_back(mk(56,     0, 4, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(69,    13, 4, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(70,     0, 5, 0, 1, 0, 0, 0));
        exp_s_q.push_back(mk(80,    10, 5, 0, 0, 0, 0, 0));
        exp_s_q.push_back(mk(83,    13, 5, 0, 1, 0, 0, 0));
        exp_s_q.push_back(mk(84,     0, 6, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(97,    13, 6, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(98,     0, 0, 1, 1, 1, 1, fcv(1)));
        exp_s_q.push_back(mk(99,     1, 0, 1, 1, 1, 0, fcv(1)));
        exp_s_q.push_back(mk(196,    0, 0, 1, 1, 1, 1, fcv(2)));
        exp_s_q.push_back(mk(197,    1, 0, 1, 1, 1, 0, fcv(2)));
        exp_s_q.push_back(mk(24990,  0, 0, 1, 1, 1, 1, fcv(255)));
        exp_s_q.push_back(mk(25088,  0, 0, 1, 1, 1, 1, fcv(0)));
        exp_s_q.push_back(mk(25186,  0, 0, 1, 1, 1, 1, fcv(1)));
        exp_s_q.push_back(mk(25187,  1, 0, 1, 1, 1, 0, fcv(1)));
        repeat (10) @(negedge vga_clk);
        rst_s_n = 1'b1;

        // Mid-frame reset at (5,2) of the 258th frame, checked before the next edge.
        wait (cyc_s == 25219);
        #2;
        exp_s_q.push_back(mk(0,      0, 0, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(1,      1, 0, 1, 1, 1, 0, 0));
        exp_s_q.push_back(mk(97,    13, 6, 0, 1, 1, 0, 0));
        exp_s_q.push_back(mk(98,     0, 0, 1, 1, 1, 1, fcv(1)));
        exp_s_q.push_back(mk(99,     1, 0, 1, 1, 1, 0, fcv(1)));
        run_s   = 1;
        rst_s_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        rst_s_n = 1'b1;
        wait (cyc_s == 105);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main / final report ----------------
    initial begin
        fork
            drive_default();
            drive_small();
        join
        @(negedge vga_clk);
        check_val("d_queue_left", exp_d_q.size(), 0);
        check_val("s_queue_left", exp_s_q.size(), 0);
        check_val("d_hs_low_per_line", hs_low_d, 96);
        check_val("d_blank_low_per_line", blank_low_d, 160);
        check_val("s_vs_low_257_frames", vs_low_s, 3598);
        check_val("s_frame_start_pulses", fs_cnt_s, 258);
        check_val("s_vs_edge_not_at_x0", vs_edge_bad_s, 0);
        check_val("s_blank_outside_active", blank_bad_s, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
